alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (>= 8).
REQ-002 The module SHALL have port clk  input  1  rising-edge clock.
REQ-003 The module SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The module SHALL have port a_in  input  WIDTH  operand A.
REQ-005 The module SHALL have port b_in  input  WIDTH  operand B (shift/rotate amount for shift ops).
REQ-006 The module SHALL have port oper  input  4  operation select, encoded per REQ-011.
REQ-007 The module SHALL have port flags_in  input  4  current flags {N,V,C,Z} at bits [3:0] = {FlagN=3, FlagV=2, FlagC=1, FlagZ=0}.
REQ-008 The module SHALL have port out  output  WIDTH  registered result.
REQ-009 The module SHALL have port flags_out  output  4  registered flags, same bit layout as flags_in.

Function
REQ-010 The module SHALL sample its inputs and register out and flags_out on every rising clk edge with no enable; latency is exactly 1 cycle and throughput is one operation per cycle.
REQ-011 Opcodes SHALL be: 0 Add a+b; 1 Adc a+b+C; 2 Sub a-b; 3 Sbc a-b-!C; 4 Rsb b-a; 5 Mul low WIDTH bits of a*b; 6 And; 7 Orr; 8 Xor; 9 Lsl; 10 Lsr; 11 Asr; 12 Rol; 13 Ror; 14 Cpy (result=b); 15 Not (result=~b).
REQ-012 Arithmetic SHALL be performed modulo 2^WIDTH, with a WIDTH+1-bit internal sum for carry.
REQ-013 Z SHALL be 1 exactly when the result is 0, and N SHALL equal result[WIDTH-1], for every opcode.
REQ-014 For Add/Adc, C SHALL be the carry out of bit WIDTH-1, and V SHALL be set when both operands have equal sign and the result sign differs.
REQ-015 For Sub/Sbc/Rsb, C SHALL be 1 when no borrow occurs (minuend >= subtrahend + borrow-in, unsigned), and V SHALL be set when the operands have different signs and the result sign differs from the minuend.
REQ-016 Sub flags SHALL support signed compare: a<b iff N!=V; a<=b iff N!=V or Z; a>b iff N==V and Z==0; a>=b iff N==V; a==b iff Z.
REQ-017 Sub flags SHALL support unsigned compare: a>=b iff C; a<b iff !C.
REQ-018 For Mul, And, Orr, Xor, Cpy and Not, C and V SHALL pass through from flags_in.
REQ-019 For Lsl, Lsr and Asr, the shift amount SHALL be the full unsigned b_in.
REQ-020 For Lsl, Lsr and Asr with amount 0, the result SHALL be a and C SHALL pass through.
REQ-021 For Lsl, Lsr and Asr with amount 1..WIDTH, C SHALL be the last bit shifted out.
REQ-022 For amount > WIDTH, Lsl and Lsr SHALL give result 0 and C=0, and Asr SHALL give all bits equal to a[WIDTH-1] with C=a[WIDTH-1].
REQ-023 V SHALL pass through for all shift ops.
REQ-024 For Rol and Ror, the amount SHALL be b_in mod WIDTH, and C and V SHALL pass through.
REQ-025 flags_in SHALL affect only Adc/Sbc (carry-in) and the pass-through fields.

Reset
REQ-026 While rst=1, out SHALL be 0 and flags_out SHALL be 4'b0000, asynchronously and regardless of clk.
REQ-027 The first operation SHALL be registered on the first rising edge after rst deasserts.
REQ-028 An operation in flight when rst asserts SHALL be discarded.

Verification
REQ-029 With WIDTH=8, Sub a=0x80, b=0x01 -> out=0x7F, flags_out={N=0,V=1,C=1,Z=0}, and signed a<b holds (N!=V).
REQ-030 With WIDTH=8, an exhaustive Sub sweep over all (a,b) pairs SHALL satisfy REQ-016 and REQ-017 with zero mismatches.
REQ-031 With WIDTH=8, Add 0xFF+0x01 -> out=0x00 with Z=1, C=1, V=0, N=0; Adc 0x7F+0x00 with C_in=1 -> out=0x80 with V=1, N=1.
REQ-032 With WIDTH=8, Lsr a=0x81, b=1 -> out=0x40 with C=1; Asr a=0x80, b=20 -> out=0xFF with C=1; Lsl with b=0 -> out=a with C=flags_in.C.
REQ-033 With WIDTH=8, And a=0xF0, b=0x0F with flags_in=4'b0110 -> out=0x00 and flags_out=4'b0111.
REQ-034 Asserting rst mid-stream SHALL force out=0 and flags_out=0 immediately, with correct results resuming one cycle after release.

Source files
------------

// File: rtl/alu.sv
// Single-cycle-latency ALU: the result and {N,V,C,Z} flags are registered every clock.
// One shared adder serves the add/subtract family; shifts use a one-bit-extended datapath to capture carry.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       oper,
    input  logic [3:0]       flags_in,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags_out
);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3,
        OP_RSB = 4'd4,  OP_MUL = 4'd5,  OP_AND = 4'd6,  OP_ORR = 4'd7,
        OP_XOR = 4'd8,  OP_LSL = 4'd9,  OP_LSR = 4'd10, OP_ASR = 4'd11,
        OP_ROL = 4'd12, OP_ROR = 4'd13, OP_CPY = 4'd14, OP_NOT = 4'd15
    } op_e;

    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    op_e              op;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_ci;
    logic [WIDTH:0]   sum;
    logic             add_v;
    logic [WIDTH:0]   lsl_ext;
    logic [WIDTH:0]   lsr_ext;
    logic [WIDTH:0]   asr_ext;
    logic [WIDTH-1:0] rot_amt;
    logic [WIDTH-1:0] res;
    logic             c_nxt;
    logic             v_nxt;
    logic             unused_flags;

    assign op = op_e'(oper);
    assign unused_flags = ^{flags_in[3], flags_in[0]};

    // Subtraction is x + ~y + carry, so the adder carry-out is the "no borrow" flag.
    always_comb begin
        add_x  = a_in;
        add_y  = b_in;
        add_ci = 1'b0;
        case (op)
            OP_ADC: add_ci = flags_in[1];
            OP_SUB: begin add_y = ~b_in; add_ci = 1'b1; end
            OP_SBC: begin add_y = ~b_in; add_ci = flags_in[1]; end
            OP_RSB: begin add_x = b_in; add_y = ~a_in; add_ci = 1'b1; end
            default: ;
        endcase
    end

    assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
    assign add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

    // The extra bit holds the last bit shifted out; oversized amounts naturally yield 0 / sign fill.
    assign lsl_ext = {1'b0, a_in} << b_in;
    assign lsr_ext = {a_in, 1'b0} >> b_in;
    assign asr_ext = $signed({a_in, 1'b0}) >>> b_in;
    assign rot_amt = b_in % W_VAL;

    always_comb begin
        res   = '0;
        c_nxt = flags_in[1];
        v_nxt = flags_in[2];
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB: begin
                res   = sum[WIDTH-1:0];
                c_nxt = sum[WIDTH];
                v_nxt = add_v;
            end
            OP_MUL: res = a_in * b_in;
            OP_AND: res = a_in & b_in;
            OP_ORR: res = a_in | b_in;
            OP_XOR: res = a_in ^ b_in;
            OP_LSL: begin
                res = lsl_ext[WIDTH-1:0];
                if (b_in != '0) c_nxt = lsl_ext[WIDTH];
            end
            OP_LSR: begin
                res = lsr_ext[WIDTH:1];
                if (b_in != '0) c_nxt = lsr_ext[0];
            end
            OP_ASR: begin
                res = asr_ext[WIDTH:1];
                if (b_in != '0) c_nxt = asr_ext[0];
            end
            OP_ROL: res = (a_in << rot_amt) | (a_in >> (W_VAL - rot_amt));
            OP_ROR: res = (a_in >> rot_amt) | (a_in << (W_VAL - rot_amt));
            OP_CPY: res = b_in;
            OP_NOT: res = ~b_in;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            flags_out <= '0;
        end else begin
            out       <= res;
            flags_out <= {res[WIDTH-1], v_nxt, c_nxt, (res == '0)};
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu at WIDTH=8: hand-computed vectors, an exhaustive Sub compare sweep, and reset checks.
module tb_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [3:0] oper;
    logic [3:0] flags_in;
    logic [7:0] out;
    logic [3:0] flags_out;

    int total = 0;
    int bad   = 0;

    alu #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .b_in     (b_in),
        .oper     (oper),
        .flags_in (flags_in),
        .out      (out),
        .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one operation, let it register, then check result and flags 1ns after the edge.
    task automatic step(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] fl,
                        input logic [7:0] exp_out, input logic [3:0] exp_fl);
        oper = op; a_in = a; b_in = b; flags_in = fl;
        @(posedge clk); #1;
        check({tag, ".out"}, {24'd0, out}, {24'd0, exp_out});
        check({tag, ".flags"}, {28'd0, flags_out}, {28'd0, exp_fl});
    endtask

    initial begin
        logic n, v, c, z;
        logic [13:0] obs_v, exp_v;
        logic [7:0]  ai, bi, diff;

        rst = 1'b1; a_in = 8'h12; b_in = 8'h34; oper = 4'd0; flags_in = 4'hF;
        @(posedge clk); #1;
        check("reset.out", {24'd0, out}, 32'd0);
        check("reset.flags", {28'd0, flags_out}, 32'd0);
        #3 rst = 1'b0;

        // flags written {N,V,C,Z}
        step("sub_80_01",  4'd2,  8'h80, 8'h01, 4'b0000, 8'h7F, 4'b0110);
        step("add_ff_01",  4'd0,  8'hFF, 8'h01, 4'b0000, 8'h00, 4'b0011);
        step("adc_7f_c1",  4'd1,  8'h7F, 8'h00, 4'b0010, 8'h80, 4'b1100);
        step("add_7f_01",  4'd0,  8'h7F, 8'h01, 4'b0000, 8'h80, 4'b1100);
        step("sub_eq",     4'd2,  8'h05, 8'h05, 4'b0000, 8'h00, 4'b0011);
        step("sbc_c0",     4'd3,  8'h10, 8'h05, 4'b0000, 8'h0A, 4'b0010);
        step("rsb_03_01",  4'd4,  8'h03, 8'h01, 4'b0000, 8'hFE, 4'b1000);
        step("mul_wrap",   4'd5,  8'h10, 8'h11, 4'b0100, 8'h10, 4'b0100);
        step("and_pass",   4'd6,  8'hF0, 8'h0F, 4'b0110, 8'h00, 4'b0111);
        step("orr",        4'd7,  8'h80, 8'h01, 4'b0000, 8'h81, 4'b1000);
        step("xor_zero",   4'd8,  8'hFF, 8'hFF, 4'b0010, 8'h00, 4'b0011);
        step("lsl_0_c1",   4'd9,  8'h5A, 8'h00, 4'b0010, 8'h5A, 4'b0010);
        step("lsl_0_c0",   4'd9,  8'h5A, 8'h00, 4'b0000, 8'h5A, 4'b0000);
        step("lsl_1",      4'd9,  8'h81, 8'h01, 4'b0000, 8'h02, 4'b0010);
        step("lsl_w",      4'd9,  8'h81, 8'h08, 4'b0000, 8'h00, 4'b0011);
        step("lsl_big",    4'd9,  8'hFF, 8'h09, 4'b0010, 8'h00, 4'b0001);
        step("lsr_1",      4'd10, 8'h81, 8'h01, 4'b0000, 8'h40, 4'b0010);
        step("lsr_w",      4'd10, 8'h80, 8'h08, 4'b0000, 8'h00, 4'b0011);
        step("lsr_big",    4'd10, 8'hFF, 8'hC8, 4'b0110, 8'h00, 4'b0101);
        step("asr_20",     4'd11, 8'h80, 8'd20, 4'b0000, 8'hFF, 4'b1010);
        step("asr_big_p",  4'd11, 8'h40, 8'd200, 4'b0010, 8'h00, 4'b0001);
        step("asr_1",      4'd11, 8'hC0, 8'h01, 4'b0010, 8'hE0, 4'b1000);
        step("rol_1",      4'd12, 8'h81, 8'h01, 4'b0110, 8'h03, 4'b0110);
        step("rol_9",      4'd12, 8'h81, 8'h09, 4'b0000, 8'h03, 4'b0000);
        step("ror_1",      4'd13, 8'h81, 8'h01, 4'b0000, 8'hC0, 4'b1000);
        step("ror_8",      4'd13, 8'h12, 8'h08, 4'b0000, 8'h12, 4'b0000);
        step("cpy_zero",   4'd14, 8'hAA, 8'h00, 4'b1111, 8'h00, 4'b0111);
        step("not_0f",     4'd15, 8'hAA, 8'h0F, 4'b0000, 8'hF0, 4'b1000);

        // Reset mid-stream: immediate clear, held through an edge, then resume.
        step("pre_rst",    4'd0,  8'h01, 8'h01, 4'b0000, 8'h02, 4'b0000);
        oper = 4'd0; a_in = 8'h03; b_in = 8'h04; flags_in = 4'b0000;
        #2 rst = 1'b1;
        #1;
        check("rst_async.out", {24'd0, out}, 32'd0);
        check("rst_async.flags", {28'd0, flags_out}, 32'd0);
        @(posedge clk); #1;
        check("rst_hold.out", {24'd0, out}, 32'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_resume.out", {24'd0, out}, 32'd7);
        check("rst_resume.flags", {28'd0, flags_out}, 32'd0);

        // Exhaustive Sub: difference plus every signed/unsigned compare predicate.
        oper = 4'd2; flags_in = 4'b0000;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                ai = 8'(i); bi = 8'(j);
                a_in = ai; b_in = bi;
                @(posedge clk); #1;
                {n, v, c, z} = flags_out;
                diff  = ai - bi;
                obs_v = {n != v, (n != v) || z, (n == v) && !z, n == v, z, c, out};
                exp_v = {$signed(ai) < $signed(bi), $signed(ai) <= $signed(bi),
                         $signed(ai) > $signed(bi), $signed(ai) >= $signed(bi),
                         ai == bi, ai >= bi, diff};
                check($sformatf("sweep_%02h_%02h", ai, bi), {18'd0, obs_v}, {18'd0, exp_v});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
